mod_float_to_fixed: RTL
=======================

# mod_float_to_fixed

Multi-cycle converter from IEEE-754 half-precision floats (1 sign, 5 exponent with bias 15, 10 mantissa) to signed two's-complement fixed point. It is the exit point of the float datapath and sits downstream of the float add/multiply units. It hands results to integer consumers such as servo-position and PWM logic. It uses the same single-pulse `in_En` / `out_Ready` handshake as the other float units.

## Interface
- `INT_W`, default 12: integer bits including sign. Legal range 2..16.
- `FRAC_W`, default 4: fraction bits. Legal range 0..10.
- `W` (localparam) = `INT_W` + `FRAC_W`. Legal range ≤ 24.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_Float`  in  16: half-precision operand, sampled on the accept edge.
- `in_En`  in  1: request. Accepted only when state is IDLE.
- `out_Fixed`  out  W: signed result, LSB = 2^-FRAC_W.
- `out_Ready`  out  1: one-cycle pulse; result and flags are valid.
- `out_Busy`  out  1: high whenever state ≠ IDLE.
- `out_Ovf`  out  1: result was saturated.
- `out_Invalid`  out  1: input was NaN.

## Operation
- FSM states: IDLE → ALIGN → ROUND → PACK → IDLE. There are no other states, and the sequence has no variable latency.
- **IDLE**
  - If `in_En` = 1: register `in_Float`, go to ALIGN.
  - Otherwise stay in IDLE.
- **ALIGN**
  - Classify the input:
    - exp = 31 with mant ≠ 0 → NaN.
    - exp = 31 with mant = 0 → ±Inf.
    - exp = 0 → zero or subnormal, treated as magnitude 0.
  - Form significand {1, mant} (11 bits).
  - Shift by e = exp − 15 − 10 + FRAC_W.
    - Left if e ≥ 0.
    - Right if e < 0: keep guard and round bits, OR all lower discarded bits into sticky.
  - Magnitude register is W+1 bits wide. If the shift would exceed it, set a pre-overflow bit.
- **ROUND**
  - Rounding mode is set by the macro (see Configuration).
  - If rounding carries past the magnitude register, set the pre-overflow bit.
- **PACK**
  - Apply the sign and saturate:
    - Positive magnitude > 2^(W−1)−1 → out 2^(W−1)−1, `out_Ovf` = 1.
    - Negative magnitude > 2^(W−1) → out −2^(W−1), `out_Ovf` = 1.
    - Negative magnitude exactly 2^(W−1) → −2^(W−1), `out_Ovf` = 0.
  - ±Inf → saturated extreme for its sign, `out_Ovf` = 1.
  - NaN → out 0, `out_Invalid` = 1, `out_Ovf` = 0.
  - −0 and subnormals → 0, no flags.
  - Register `out_Fixed`, `out_Ovf`, `out_Invalid`; assert `out_Ready`; go to IDLE.
- Outputs and flags hold their values until the next PACK overwrites them. Only `out_Ready` is a pulse.

## Timing
- Reset (`rst` low, any time, including mid-conversion): state = IDLE; `out_Fixed` = 0, `out_Ready` = 0, `out_Busy` = 0, `out_Ovf` = 0, `out_Invalid` = 0. An in-flight operand is discarded and no `out_Ready` is issued for it.
- Accept edge E0. `out_Busy` is high from after E0 through E3.
- `out_Fixed` and `out_Ready` update at edge E3. `out_Ready` drops at E4.
- Latency: 3 cycles from accept to result.
- `in_En` is ignored at E1–E3, so there is no queueing.
- The next accept is possible at E4. Maximum throughput is one conversion per 4 cycles.
- `in_Float` may change freely after E0.

## Configuration
- `F2F_ROUND_NEAREST_EN`
  - Defined: round to nearest, ties to even, on the magnitude. This is symmetric for both signs.
  - Undefined: truncate toward zero (drop guard, round and sticky bits).
- In both builds the ROUND state is still traversed, so latency is identical.

## Test plan
- Reset low mid-ALIGN with input 0x5E40 → all outputs 0, no `out_Ready` pulse; the next accept behaves normally.
- 0x5E40 (400) → 0x1900 at E3. 0xDE40 (−400) → 0xE700. Each shows one `out_Ready` pulse and no flags. A second `in_En` held high during E1–E3 is ignored.
- 0x3C60 (1.09375) → 0x0012 with the macro, 0x0011 without. 0xBC60 → 0xFFEE with the macro, 0xFFEF without.
- 0x6B2F (3678) → 0x7FFF with `out_Ovf` = 1. 0xE800 (−2048) → 0x8000 with `out_Ovf` = 0. 0x7C00 → 0x7FFF with `out_Ovf` = 1. 0xFC00 → 0x8000 with `out_Ovf` = 1.
- 0x7E00 (NaN) → 0x0000 with `out_Invalid` = 1. 0x8000 (−0) → 0x0000, no flags. 0x03FF (subnormal) → 0x0000, no flags.
- Back-to-back: `in_En` held high continuously with 0x3C00 then 0x4000 → results 0x0010 then 0x0020, exactly 4 cycles apart.

Source files
------------

// File: rtl/mod_float_to_fixed.sv
// mod_float_to_fixed
// Converts an IEEE-754 half-precision float to signed two's-complement fixed
// point with INT_W integer bits (sign included) and FRAC_W fraction bits.
// The conversion always takes IDLE -> ALIGN -> ROUND -> PACK -> IDLE.
// The result appears 3 cycles after the accept edge.
//
// Optional build macro:
//   F2F_ROUND_NEAREST_EN  defined   : round to nearest, ties to even, on the magnitude
//                         undefined : truncate toward zero
//
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  asynchronous reset, active low
//   in_Float     in  16  half-precision operand, sampled on the accept edge
//   in_En        in   1  request, accepted only while idle
//   out_Fixed    out  W  signed result, LSB = 2^-FRAC_W
//   out_Ready    out  1  one-cycle pulse when result and flags are valid
//   out_Busy     out  1  high while a conversion is in flight
//   out_Ovf      out  1  result was saturated
//   out_Invalid  out  1  operand was NaN
module mod_float_to_fixed #(
    parameter int INT_W  = 12,
    parameter int FRAC_W = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [15:0]                     in_Float,
    input  logic                            in_En,
    output logic signed [INT_W+FRAC_W-1:0]  out_Fixed,
    output logic                            out_Ready,
    output logic                            out_Busy,
    output logic                            out_Ovf,
    output logic                            out_Invalid
);
    localparam int W = INT_W + FRAC_W;

`ifdef F2F_ROUND_NEAREST_EN
    localparam logic ROUND_NEAREST = 1'b1;
`else
    localparam logic ROUND_NEAREST = 1'b0;
`endif

    // Right shift amount is relative to the LSB of the 11-bit significand.
    localparam logic signed [6:0] SHIFT_OFS = 7'(FRAC_W - 25);
    localparam logic [W:0]        POS_MAX   = (W+1)'((1 << (W-1)) - 1);
    localparam logic [W:0]        NEG_MAG   = (W+1)'(1 << (W-1));

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ROUND, S_PACK} state_t;
    state_t r_state;

    logic [15:0] r_float_p0;
    logic        r_sign_p1, r_nan_p1, r_pre_ovf_p1;
    logic        r_g_p1, r_r_p1, r_s_p1;
    logic [W:0]  r_mag_p1;
    logic        r_pre_ovf_p2;
    logic [W:0]  r_mag_p2;

    // Returns {carry, magnitude}; the carry marks a round-up past the register.
    function automatic logic [W+1:0] f_round(input logic [W:0] mag,
                                             input logic g, input logic r, input logic s);
        logic inc;
        inc = ROUND_NEAREST & g & (r | s | mag[0]);
        return {1'b0, mag} + (W+2)'(inc);
    endfunction

    // Returns {ovf, fixed}. A negative magnitude of exactly 2^(W-1) is representable.
    function automatic logic [W:0] f_saturate(input logic sign, input logic nan,
                                              input logic pre_ovf, input logic [W:0] mag);
        logic [W:0] neg;
        neg = -mag;
        if (nan)
            return '0;
        else if (!sign)
            return (pre_ovf || mag > POS_MAX) ? {1'b1, POS_MAX[W-1:0]} : {1'b0, mag[W-1:0]};
        else
            return (pre_ovf || mag > NEG_MAG) ? {1'b1, NEG_MAG[W-1:0]} : {1'b0, neg[W-1:0]};
    endfunction

    logic [4:0]         w_exp;
    logic [9:0]         w_mant;
    logic [10:0]        w_sig;
    logic signed [6:0]  w_e;
    logic [6:0]         w_rsh;
    logic [36:0]        w_rext;
    logic [47:0]        w_lsh;
    logic [47:0]        w_int;
    logic               w_big, w_nan, w_inf, w_zero;
    logic [W+1:0]       w_rnd;
    logic [W:0]         w_sat;

    assign w_exp  = r_float_p0[14:10];
    assign w_mant = r_float_p0[9:0];
    assign w_sig  = {1'b1, w_mant};
    assign w_e    = $signed({2'b00, w_exp}) + SHIFT_OFS;
    assign w_rsh  = -w_e;
    // 26 spare low bits hold guard, round and sticky for shifts up to 24.
    assign w_rext = {w_sig, 26'd0} >> w_rsh;
    assign w_lsh  = {37'd0, w_sig} << w_e;
    assign w_int  = w_e[6] ? {37'd0, w_rext[36:26]} : w_lsh;
    assign w_big  = |w_int[47:W+1];
    assign w_nan  = (&w_exp) & (|w_mant);
    assign w_inf  = (&w_exp) & ~(|w_mant);
    assign w_zero = ~(|w_exp);
    assign w_rnd  = f_round(r_mag_p1, r_g_p1, r_r_p1, r_s_p1);
    assign w_sat  = f_saturate(r_sign_p1, r_nan_p1, r_pre_ovf_p2, r_mag_p2);

    // Control and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            out_Fixed   <= '0;
            out_Ready   <= 1'b0;
            out_Busy    <= 1'b0;
            out_Ovf     <= 1'b0;
            out_Invalid <= 1'b0;
        end else begin
            out_Ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_En) begin
                        r_state  <= S_ALIGN;
                        out_Busy <= 1'b1;
                    end
                end
                S_ALIGN: r_state <= S_ROUND;
                S_ROUND: r_state <= S_PACK;
                S_PACK: begin
                    r_state     <= S_IDLE;
                    out_Busy    <= 1'b0;
                    out_Ready   <= 1'b1;
                    out_Fixed   <= w_sat[W-1:0];
                    out_Ovf     <= w_sat[W];
                    out_Invalid <= r_nan_p1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath: p0 operand capture, p1 alignment, p2 rounding
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_En)
            r_float_p0 <= in_Float;
        if (r_state == S_ALIGN) begin
            r_sign_p1 <= r_float_p0[15];
            r_nan_p1  <= w_nan;
            if (w_nan || w_zero || w_inf) begin
                r_mag_p1     <= '0;
                r_g_p1       <= 1'b0;
                r_r_p1       <= 1'b0;
                r_s_p1       <= 1'b0;
                r_pre_ovf_p1 <= w_inf;
            end else begin
                r_mag_p1     <= w_int[W:0];
                r_g_p1       <= w_e[6] & w_rext[25];
                r_r_p1       <= w_e[6] & w_rext[24];
                r_s_p1       <= w_e[6] & (|w_rext[23:0]);
                r_pre_ovf_p1 <= w_big;
            end
        end
        if (r_state == S_ROUND) begin
            r_mag_p2     <= w_rnd[W:0];
            r_pre_ovf_p2 <= r_pre_ovf_p1 | w_rnd[W+1];
        end
    end
endmodule
